slice_mem_port: RTL and testbench
=================================

Name: slice_mem_port

Overview:
- Memory-side responder for the column-parity encoder.
- Buffers one 64-line x 25-bit state, loaded from an input stream.
- Serves lines to the encoder by encoder-driven index, and captures the encoder's write-backs in place.
- Streams the encoded state back out once the encoder reports done; this is the counterpart to the encoder's line_in / write_enable / write_value interface.

Parameters:
- LINES, 64, number of state lines (slices) per block.
- WIDTH, 25, bits per line (5x5 lane bits of one slice).
- IDX_W, 7, width of encoder index input (matches encoder cnt_value).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- ld_valid  input  1  load stream data valid.
- ld_data  input  WIDTH  load stream line.
- ld_ready  output  1  block accepts a load line.
- enc_start  output  1  one-cycle start pulse to encoder.
- enc_cnt  input  IDX_W  encoder line index.
- enc_line  output  WIDTH  line at enc_cnt, to encoder line_in.
- enc_wr_en  input  1  encoder write enable.
- enc_wr_data  input  WIDTH  encoder write value.
- enc_done  input  1  encoder completion (counter carry-out).
- rd_valid  output  1  output stream valid.
- rd_data  output  WIDTH  output stream line.
- rd_ready  input  1  output stream consumer ready.
- busy  output  1  high in START, RUN and DRAIN.
- err  output  1  sticky: write attempted with enc_cnt >= LINES.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; ld_ptr and rd_ptr go to 0.
  - Outputs: ld_ready=1, enc_start=0, rd_valid=0, busy=0, err=0.
  - Memory contents are not cleared.
- FSM states IDLE, START, RUN, DRAIN:
  - IDLE: ld_ready=1. Each cycle with ld_valid=1, mem[ld_ptr] is written with ld_data and ld_ptr increments. On the handshake at ld_ptr=LINES-1, go to START and set ld_ptr=0. err clears on the first load handshake.
  - START: one cycle; enc_start=1; then go to RUN.
  - RUN:
    - enc_line is combinational: mem[enc_cnt] when enc_cnt < LINES, else 0.
    - enc_wr_en=1 with enc_cnt < LINES writes enc_wr_data to mem[enc_cnt] at the clock edge. Same-cycle read returns the old value (read-before-write).
    - enc_wr_en=1 with enc_cnt >= LINES: write is dropped and err is set.
    - enc_done=1 goes to DRAIN next cycle. A write in the same cycle as enc_done is still committed.
  - DRAIN:
    - rd_valid=1 and rd_data=mem[rd_ptr] (combinational).
    - On rd_valid & rd_ready, rd_ptr increments. On the handshake at rd_ptr=LINES-1, go to IDLE and set rd_ptr=0.
    - rd_data is stable while rd_ready=0.
- Outside their owning state, inputs are ignored:
  - ld_valid is ignored outside IDLE (ld_ready=0).
  - enc_wr_en and enc_done are ignored outside RUN.
  - rd_ready is ignored outside DRAIN.
- enc_line is also driven in the other states (same combinational read), but is meaningful only in RUN.
- Latency:
  - enc_start rises 1 cycle after the 64th load handshake.
  - rd_valid rises 1 cycle after enc_done is sampled.
  - Minimum block turnaround is 64 + 1 + encoder cycles + 1 + 64.
- Reset asserted mid-operation (any state) aborts immediately. After release, a complete new load is required and partial load progress is lost.
- Pointers are log2(LINES) bits wide. Wrap happens only through the explicit state transitions; there is no modular overrun.

Test Plan:
- Reset, then load lines i -> value i (i=0..63) with ld_valid held high -> ld_ready drops and enc_start=1 exactly on the cycle after the 64th handshake; busy=1.
- In RUN, sweep enc_cnt 0..63 while writing enc_wr_data = enc_line ^ 25'h1FFFFFF, and pulse enc_done at the end -> DRAIN outputs ~i & 25'h1FFFFFF for i=0..63 in order.
- In DRAIN, toggle rd_ready randomly (about 50%) -> rd_data holds while stalled, no lines are lost or duplicated, and the state returns to IDLE after 64 handshakes.
- In RUN, drive enc_wr_en=1 with enc_cnt=64 -> memory is unchanged, err=1 and stays set until the next load handshake; enc_line=0 for enc_cnt=64.
- Assert enc_done in IDLE, enc_wr_en in DRAIN, and ld_valid in RUN -> no state change and no memory change.
- Assert rst after 30 load lines -> all outputs return to reset values; a following full 64-line load plus run produces the correct output.

Source files
------------

// File: rtl/slice_mem_port.sv
// Memory-side responder for the column-parity encoder: buffers one block of
// state lines, serves/captures encoder accesses in place, then streams it out.
module slice_mem_port #(
    parameter int LINES = 64,
    parameter int WIDTH = 25,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    output logic             enc_start,
    input  logic [IDX_W-1:0] enc_cnt,
    output logic [WIDTH-1:0] enc_line,
    input  logic             enc_wr_en,
    input  logic [WIDTH-1:0] enc_wr_data,
    input  logic             enc_done,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic             busy,
    output logic             err
);

    localparam int PTR_W = $clog2(LINES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_ld_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [LINES];

    logic             w_ld_hs;
    logic             w_rd_hs;
    logic             w_cnt_ok;
    logic [PTR_W-1:0] w_cnt_idx;
    logic             w_enc_wr;
    logic             w_bad_wr;

    // Handshakes are qualified by state so stray inputs in other states do nothing.
    assign w_ld_hs   = ld_valid && (r_state == ST_IDLE);
    assign w_rd_hs   = rd_ready && (r_state == ST_DRAIN);
    assign w_cnt_ok  = (enc_cnt < IDX_W'(LINES));
    assign w_cnt_idx = enc_cnt[PTR_W-1:0];
    assign w_enc_wr  = enc_wr_en && (r_state == ST_RUN) && w_cnt_ok;
    assign w_bad_wr  = enc_wr_en && (r_state == ST_RUN) && !w_cnt_ok;

    assign ld_ready  = (r_state == ST_IDLE);
    assign enc_start = (r_state == ST_START);
    assign rd_valid  = (r_state == ST_DRAIN);
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;
    assign enc_line  = w_cnt_ok ? r_mem[w_cnt_idx] : {WIDTH{1'b0}};
    assign rd_data   = r_mem[r_rd_ptr];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ld_hs && (r_ld_ptr == PTR_LAST)) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (enc_done) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_rd_hs && (r_rd_ptr == PTR_LAST)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Load and drain pointers; wrap only at the block boundary transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_ld_hs) begin
                r_ld_ptr <= (r_ld_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_ld_ptr + 1'b1;
            end
            if (w_rd_hs) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_rd_ptr + 1'b1;
            end
        end
    end

    // Sticky out-of-range write flag, cleared by the next load handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_bad_wr) begin
            r_err <= 1'b1;
        end else if (w_ld_hs) begin
            r_err <= 1'b0;
        end
    end

    // Line storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ld_hs) begin
            r_mem[r_ld_ptr] <= ld_data;
        end else if (w_enc_wr) begin
            r_mem[w_cnt_idx] <= enc_wr_data;
        end
    end

endmodule

// File: tb/tb_slice_mem_port.sv
// Directed bench for slice_mem_port: the bench plays loader, encoder and
// consumer; drained lines are checked against a scoreboard queue.
module tb_slice_mem_port;

    localparam int LINES = 64;
    localparam int WIDTH = 25;
    localparam int IDX_W = 7;
    localparam logic [WIDTH-1:0] MASK = 25'h1FFFFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_ready;
    logic             enc_start;
    logic [IDX_W-1:0] enc_cnt;
    logic [WIDTH-1:0] enc_line;
    logic             enc_wr_en;
    logic [WIDTH-1:0] enc_wr_data;
    logic             enc_done;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ready;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] sb[$];

    slice_mem_port #(.LINES(LINES), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .enc_start(enc_start), .enc_cnt(enc_cnt), .enc_line(enc_line),
        .enc_wr_en(enc_wr_en), .enc_wr_data(enc_wr_data), .enc_done(enc_done),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pat(input int blk, input int i);
        logic [WIDTH-1:0] v;
        case (blk)
            0:       v = WIDTH'(i);
            1:       v = WIDTH'(i * 3 + 5);
            default: v = 25'h1555555 ^ WIDTH'(i);
        endcase
        return v;
    endfunction

    // Output monitor: pops the scoreboard on each accepted line, checks stall stability.
    initial begin
        logic             hold_v;
        logic [WIDTH-1:0] hold_d;
        logic [WIDTH-1:0] exp;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (hold_v && rd_valid) check("rd_hold", rd_data, hold_d);
            hold_v = 1'b0;
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    check("rd_extra", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("rd_data", rd_data, exp);
                end
            end else if (rd_valid) begin
                hold_v = 1'b1;
                hold_d = rd_data;
            end
        end
    end

    task automatic load(input int blk);
        for (int i = 0; i < LINES; i++) begin
            ld_valid = 1'b1;
            ld_data  = pat(blk, i);
            if (i == LINES - 1) begin
                check("pre_start_enc_start", enc_start, 0);
                check("pre_start_ld_ready", ld_ready, 1);
            end
            @(posedge clk); #1;
            if (i == 0) check("err_clear_on_load", err, 0);
        end
        check("start_enc_start", enc_start, 1);
        check("start_ld_ready", ld_ready, 0);
        check("start_busy", busy, 1);
        ld_valid = 1'b0;
        @(posedge clk); #1;
        check("run_enc_start", enc_start, 0);
        check("run_busy", busy, 1);
    endtask

    task automatic run(input int blk, input logic bad);
        if (bad) begin
            enc_cnt     = 7'd64;
            enc_wr_en   = 1'b1;
            enc_wr_data = 25'h0001234;
            ld_valid    = 1'b1;
            ld_data     = 25'h0000000;
            #1;
            check("oob_enc_line", enc_line, 0);
            check("run_ld_ready", ld_ready, 0);
            @(posedge clk); #1;
            check("oob_err_set", err, 1);
            ld_valid = 1'b0;
        end
        for (int i = 0; i < LINES; i++) begin
            enc_cnt     = IDX_W'(i);
            enc_wr_en   = 1'b1;
            enc_wr_data = pat(blk, i) ^ MASK;
            enc_done    = (i == LINES - 1);
            #1;
            check("enc_line", enc_line, pat(blk, i));
            sb.push_back(pat(blk, i) ^ MASK);
            @(posedge clk); #1;
        end
        enc_wr_en = 1'b0;
        enc_done  = 1'b0;
        check("drain_rd_valid", rd_valid, 1);
        check("drain_busy", busy, 1);
        check("drain_err", err, bad);
    endtask

    task automatic drain(input logic noise);
        int budget;
        budget      = 0;
        enc_wr_en   = noise;
        enc_done    = noise;
        enc_cnt     = 7'd63;
        enc_wr_data = 25'h0000000;
        while (sb.size() > 0 && budget < 1000) begin
            rd_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 1000) check("drain_timeout", 32'd1, 32'd0);
        rd_ready  = 1'b0;
        enc_wr_en = 1'b0;
        enc_done  = 1'b0;
        check("idle_rd_valid", rd_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_ld_ready", ld_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, ld_ready, 1);
        check({tag, "_enc_start"}, enc_start, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst = 1'b1;
        ld_valid = 1'b0; ld_data = '0; enc_cnt = '0; enc_wr_en = 1'b0;
        enc_wr_data = '0; enc_done = 1'b0; rd_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        load(0);
        run(0, 1'b0);
        drain(1'b0);

        // Encoder and consumer inputs in IDLE must not move the FSM.
        enc_done = 1'b1; enc_wr_en = 1'b1; enc_cnt = 7'd5; rd_ready = 1'b1;
        @(posedge clk); #1;
        check("ign_idle_busy", busy, 0);
        check("ign_idle_ld_ready", ld_ready, 1);
        check("ign_idle_rd_valid", rd_valid, 0);
        enc_done = 1'b0; enc_wr_en = 1'b0; rd_ready = 1'b0;

        load(1);
        run(1, 1'b1);
        drain(1'b1);
        check("err_sticky_idle", err, 1);

        // Partial load then reset: progress is lost.
        for (int i = 0; i < 30; i++) begin
            ld_valid = 1'b1;
            ld_data  = 25'h0ABCDEF;
            @(posedge clk); #1;
            if (i == 0) check("err_clear_partial", err, 0);
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        load(2);
        run(2, 1'b0);
        drain(1'b0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
